// File: rtl/merger_out_sink.sv
// rtl/merger_out_sink.sv - merger output sink: bundle buffer, registered back-pressure, terminator counting (optional SORT_CHECK_EN)
module merger_out_sink #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [8*DATA_WIDTH-1:0] i_data,
    input  logic                    i_write,
    output logic                    o_ready,
    output logic [8*DATA_WIDTH-1:0] o_data,
    output logic                    o_valid,
    output logic                    o_last,
    input  logic                    i_ready,
    output logic [CNT_WIDTH-1:0]    o_stream_count,
    output logic                    o_stream_done,
    output logic                    o_overflow,
    output logic                    o_order_err
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int BUNDLE_W = 8 * DATA_WIDTH;

    localparam logic [PTR_W-1:0]     PTR_ONE      = 1;
    localparam logic [PTR_W:0]       OCC_ONE      = 1;
    localparam logic [PTR_W:0]       OCC_FULL     = (PTR_W+1)'(DEPTH);
    // ready stays high only if the occupancy plus one write already in flight
    // (when ready is currently high) plus one more still fits.
    localparam logic [PTR_W:0]       OCC_LIM_RDY  = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0]       OCC_LIM_IDLE = (PTR_W+1)'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || KEY_WIDTH > DATA_WIDTH) begin : g_param_check
        $error("merger_out_sink: DEPTH must be a power of 2 >= 4 and KEY_WIDTH <= DATA_WIDTH");
    end

    logic [BUNDLE_W-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]     last_q;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       occ_q, occ_d;
    logic                 ready_q, ready_d;
    logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d, stream_count_q, stream_count_d;
    logic                 stream_done_q, stream_done_d;
    logic                 overflow_q, overflow_d;
    logic                 full, enq, deq, is_term;

    assign full    = (occ_q == OCC_FULL);
    assign is_term = (i_data[DATA_WIDTH-1:0] == '0);
    assign enq     = i_write && !full && !i_rst;
    assign o_valid = (occ_q != '0);
    assign deq     = o_valid && i_ready;

    assign o_data         = mem_q[rd_ptr_q];
    assign o_last         = o_valid && last_q[rd_ptr_q];
    assign o_ready        = ready_q;
    assign o_stream_count = stream_count_q;
    assign o_stream_done  = stream_done_q;
    assign o_overflow     = overflow_q;

    // bundle storage with per-entry terminator flag; contents need no reset
    always_ff @(posedge i_clk) begin
        if (enq) begin
            mem_q[wr_ptr_q]  <= i_data;
            last_q[wr_ptr_q] <= is_term;
        end
    end

    // next-state for pointers, occupancy, back-pressure and stream counters
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occ_d          = occ_q;
        run_cnt_d      = run_cnt_q;
        stream_count_d = stream_count_q;
        stream_done_d  = 1'b0;
        overflow_d     = overflow_q || (i_write && full);
        if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (enq && !deq) begin
            occ_d = occ_q + OCC_ONE;
        end else if (!enq && deq) begin
            occ_d = occ_q - OCC_ONE;
        end
        ready_d = ready_q ? (occ_d <= OCC_LIM_RDY) : (occ_d <= OCC_LIM_IDLE);
        if (enq) begin
            if (is_term) begin
                stream_count_d = run_cnt_q;
                run_cnt_d      = '0;
                stream_done_d  = 1'b1;
            end else if (run_cnt_q != '1) begin
                run_cnt_d = run_cnt_q + CNT_ONE;
            end
        end
    end

    // control state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            ready_q        <= 1'b0;
            run_cnt_q      <= '0;
            stream_count_q <= '0;
            stream_done_q  <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            ready_q        <= ready_d;
            run_cnt_q      <= run_cnt_d;
            stream_count_q <= stream_count_d;
            stream_done_q  <= stream_done_d;
            overflow_q     <= overflow_d;
        end
    end

`ifdef SORT_CHECK_EN
    logic [KEY_WIDTH-1:0]  max_key_q, max_key_d, bundle_max;
    logic                  order_err_q, order_err_d, sort_viol;
    logic [DATA_WIDTH-1:0] tuple;
    logic [KEY_WIDTH-1:0]  tuple_key;

    // compare every non-padding key against the previous bundle's maximum
    always_comb begin
        bundle_max = '0;
        sort_viol  = 1'b0;
        tuple      = '0;
        tuple_key  = '0;
        for (int i = 0; i < 8; i++) begin
            tuple     = i_data[i*DATA_WIDTH +: DATA_WIDTH];
            tuple_key = tuple[KEY_WIDTH-1:0];
            if (tuple != '0) begin
                if (tuple_key < max_key_q) sort_viol = 1'b1;
                if (tuple_key > bundle_max) bundle_max = tuple_key;
            end
        end
        max_key_d   = max_key_q;
        order_err_d = order_err_q;
        if (enq) begin
            if (is_term) begin
                max_key_d = '0;
            end else begin
                max_key_d   = bundle_max;
                order_err_d = order_err_q || sort_viol;
            end
        end
    end

    // sort tracking registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            max_key_q   <= '0;
            order_err_q <= 1'b0;
        end else begin
            max_key_q   <= max_key_d;
            order_err_q <= order_err_d;
        end
    end

    assign o_order_err = order_err_q;
`else
    assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_merger_out_sink.sv
// tb/tb_merger_out_sink.sv - directed self-checking bench for merger_out_sink
module tb_merger_out_sink;

    localparam int DW    = 128;
    localparam int BW    = 8 * DW;
    localparam int DEPTH = 16;
`ifdef SORT_CHECK_EN
    localparam bit SORT_ON = 1'b1;
`else
    localparam bit SORT_ON = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [BW-1:0] i_data;
    logic          i_write;
    logic          o_ready;
    logic [BW-1:0] o_data;
    logic          o_valid;
    logic          o_last;
    logic          i_ready;
    logic [31:0]   o_stream_count;
    logic          o_stream_done;
    logic          o_overflow;
    logic          o_order_err;

    int checks = 0;
    int errors = 0;

    merger_out_sink #(.DATA_WIDTH(DW), .KEY_WIDTH(80), .DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_write(i_write),
        .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .o_last(o_last),
        .i_ready(i_ready), .o_stream_count(o_stream_count), .o_stream_done(o_stream_done),
        .o_overflow(o_overflow), .o_order_err(o_order_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs[159:0], exp[159:0]);
        end
    endtask

    // tuple i carries key first+i for i < n, remaining tuples are zero padding
    function automatic logic [BW-1:0] mk_seq(input int first, input int n);
        logic [BW-1:0] b = '0;
        for (int i = 0; i < n; i++) b[i*DW +: DW] = DW'(first + i);
        return b;
    endfunction

    initial begin
        int keys [4] = '{5, 9, 12, 0};
        int nw;
        logic prev_rdy;

        i_rst = 1'b1; i_write = 1'b0; i_data = '0; i_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready_c1", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        i_rst = 1'b0;
        tick();
        chk("rst_ready_c2", o_ready, 1);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_order_err", o_order_err, 0);
        chk("rst_done", o_stream_done, 0);
        chk("rst_count", o_stream_count, 0);

        // short stream 5, 9, 12, terminator with downstream always ready
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_write = 1'b1;
            i_data  = mk_seq(keys[k], 1);
            tick();
            chk("s1_valid", o_valid, 1);
            chk("s1_data", o_data, mk_seq(keys[k], 1));
            chk("s1_last", o_last, (k == 3));
            chk("s1_done", o_stream_done, (k == 3));
        end
        i_write = 1'b0;
        chk("s1_count", o_stream_count, 3);
        tick();
        chk("s1_empty", o_valid, 0);
        chk("s1_done_pulse", o_stream_done, 0);

        // compliant merger against a stalled consumer
        i_ready = 1'b0; prev_rdy = 1'b0; nw = 0;
        for (int c = 0; c < 40; c++) begin
            i_write  = prev_rdy;
            i_data   = mk_seq(100 + nw, 1);
            prev_rdy = o_ready;
            tick();
            if (i_write) nw++;
        end
        i_write = 1'b0;
        chk("bp_writes", nw, 16);
        chk("bp_ready_low", o_ready, 0);
        chk("bp_overflow", o_overflow, 0);
        i_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("bp_drain_valid", o_valid, 1);
            chk("bp_drain_data", o_data, mk_seq(100 + k, 1));
            tick();
        end
        chk("bp_drained", o_valid, 0);

        // non-compliant writer: 17 writes into 16 entries
        i_ready = 1'b0; i_write = 1'b1;
        for (int k = 0; k < 17; k++) begin
            i_data = mk_seq(200 + k, 1);
            if (k == 16) chk("ov_before", o_overflow, 0);
            tick();
        end
        i_write = 1'b0;
        chk("ov_set", o_overflow, 1);
        chk("ov_valid", o_valid, 1);
        chk("ov_head", o_data, mk_seq(200, 1));
        i_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("ov_drain_data", o_data, mk_seq(200 + k, 1));
            tick();
        end
        chk("ov_drained", o_valid, 0);
        chk("ov_sticky", o_overflow, 1);

        // reset with 7 bundles buffered and a write in the reset cycle
        i_ready = 1'b0; i_write = 1'b1;
        for (int k = 0; k < 7; k++) begin
            i_data = mk_seq(300 + k, 1);
            tick();
        end
        i_rst = 1'b1; i_data = mk_seq(999, 1);
        tick();
        i_rst = 1'b0; i_write = 1'b0;
        chk("mr_valid", o_valid, 0);
        chk("mr_ready", o_ready, 0);
        chk("mr_overflow", o_overflow, 0);
        chk("mr_count", o_stream_count, 0);
        tick();
        i_write = 1'b1; i_data = '0;
        tick();
        i_write = 1'b0;
        chk("mr_term_done", o_stream_done, 1);
        chk("mr_term_count", o_stream_count, 0);
        chk("mr_term_last", o_last, 1);
        i_ready = 1'b1;
        tick();
        chk("mr_empty", o_valid, 0);

        // sort checking: descending key across bundles
        i_write = 1'b1; i_data = mk_seq(10, 8);
        tick();
        chk("so_first", o_order_err, 0);
        i_data = mk_seq(15, 1);
        tick();
        i_write = 1'b0;
        chk("so_violation", o_order_err, SORT_ON);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("so_rst", o_order_err, 0);
        tick();
        i_write = 1'b1; i_data = mk_seq(10, 8);
        tick();
        i_data = '0;
        tick();
        i_data = mk_seq(1, 8);
        tick();
        i_data = mk_seq(9, 1);
        tick();
        i_write = 1'b0;
        chk("so_new_stream", o_order_err, 0);
        chk("so_count", o_stream_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
